// File: rtl/n64_gamma_correct.sv
// Per-pixel gamma correction on the N64 VCLK video path (R/G/B LUT, sync bits delay-matched).
// Define GAMMA_OUT_REG_EN to add a third, output-side register stage.
module n64_gamma_correct #(
  parameter int unsigned COLOR_W = 7
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   nVDSYNC,
  input  logic [3:0]             gammaparams_i,
  input  logic [3*COLOR_W+3:0]   video_data_i,
  output logic [3*COLOR_W+3:0]   video_data_o
);

  localparam int unsigned DW     = 3*COLOR_W+4;
  localparam int unsigned NCURVE = 9;
  localparam int unsigned NENT   = 2**COLOR_W;
  localparam int unsigned LUT_W  = NCURVE*NENT*COLOR_W;
  localparam int unsigned BYPASS = 5;

  function automatic real curve_gamma(input int unsigned c);
    case (c)
      0:       return 0.70;
      1:       return 0.75;
      2:       return 0.80;
      3:       return 0.85;
      4:       return 0.90;
      6:       return 1.10;
      7:       return 1.20;
      8:       return 1.30;
      default: return 1.00;
    endcase
  endfunction

  // All curves are flattened into one constant vector evaluated at elaboration;
  // the bypass curve is written as exact identity to avoid rounding noise.
  function automatic logic [LUT_W-1:0] build_lut();
    logic [LUT_W-1:0] lut;
    real              xn;
    real              v;
    int unsigned      q;
    lut = '0;
    for (int unsigned c = 0; c < NCURVE; c++) begin
      for (int unsigned x = 0; x < NENT; x++) begin
        if (c == BYPASS) begin
          q = x;
        end else begin
          xn = real'(x) / real'(NENT-1);
          v  = real'(NENT-1) * (xn ** (1.0 / curve_gamma(c))) + 0.5;
          q  = $rtoi(v);
        end
        lut[(c*NENT+x)*COLOR_W +: COLOR_W] = q[COLOR_W-1:0];
      end
    end
    return lut;
  endfunction

  localparam logic [LUT_W-1:0] GAMMA_LUT = build_lut();

  function automatic logic [COLOR_W-1:0] lookup(input logic [3:0] code,
                                                 input logic [COLOR_W-1:0] x);
    int unsigned sel;
    sel = (code > 4'd8) ? BYPASS : int'(code);
    return GAMMA_LUT[(sel*NENT + int'(x))*COLOR_W +: COLOR_W];
  endfunction

  logic [DW-1:0]      s1_data;
  logic [3:0]         s1_code;
  logic [DW-1:0]      s2_data;
  logic [COLOR_W-1:0] r_lut, g_lut, b_lut;

  always_comb begin
    r_lut = lookup(s1_code, s1_data[3*COLOR_W-1 -: COLOR_W]);
    g_lut = lookup(s1_code, s1_data[2*COLOR_W-1 -: COLOR_W]);
    b_lut = lookup(s1_code, s1_data[COLOR_W-1:0]);
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      s1_data <= '0;
      s1_code <= '0;
      s2_data <= '0;
    end else if (!nVDSYNC) begin
      s1_data <= video_data_i;
      s1_code <= gammaparams_i;
      s2_data <= {s1_data[DW-1 -: 4], r_lut, g_lut, b_lut};
    end
  end

`ifdef GAMMA_OUT_REG_EN
  logic [DW-1:0] s3_data;

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST)
      s3_data <= '0;
    else if (!nVDSYNC)
      s3_data <= s2_data;
  end

  assign video_data_o = s3_data;
`else
  assign video_data_o = s2_data;
`endif

endmodule

// File: tb/tb_n64_gamma_correct.sv
// Scoreboard bench for n64_gamma_correct: stimulus pushes hand-computed words, a monitor pops per enabled cycle.
`timescale 1ns/1ps
module tb_n64_gamma_correct;

`ifdef GAMMA_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        VCLK = 1'b0;
  logic        nRST;
  logic        nVDSYNC;
  logic [3:0]  gammaparams_i;
  logic [24:0] video_data_i;
  logic [24:0] video_data_o;

  logic [24:0] exp_q [$];
  int          en_cnt = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  n64_gamma_correct #(.COLOR_W(7)) dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .nVDSYNC       (nVDSYNC),
    .gammaparams_i (gammaparams_i),
    .video_data_i  (video_data_i),
    .video_data_o  (video_data_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive_px(input logic [3:0] code, input logic [3:0] sync,
                          input logic [6:0] r, input logic [6:0] g, input logic [6:0] b,
                          input logic [6:0] er, input logic [6:0] eg, input logic [6:0] eb);
    @(negedge VCLK);
    nVDSYNC       = 1'b0;
    gammaparams_i = code;
    video_data_i  = {sync, r, g, b};
    exp_q.push_back({sync, er, eg, eb});
  endtask

  task automatic hold(input int n);
    logic [24:0] ref_out;
    @(negedge VCLK);
    nVDSYNC       = 1'b1;
    video_data_i  = 25'($urandom);
    gammaparams_i = 4'($urandom);
    ref_out       = video_data_o;
    for (int i = 1; i < n; i++) begin
      @(negedge VCLK);
      check("hold_stable", video_data_o, ref_out);
      video_data_i  = 25'($urandom);
      gammaparams_i = 4'($urandom);
    end
  endtask

  // Monitor: output reflects the pixel issued LAT-1 enabled edges earlier.
  initial begin
    forever begin
      @(posedge VCLK);
      if (nRST && !nVDSYNC) begin
        en_cnt++;
        #1;
        if (en_cnt < LAT)
          check("latency_zero", video_data_o, 25'd0);
        else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty: got %h expected none queued", video_data_o);
        end else
          check("pixel", video_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] x;
    nRST          = 1'b0;
    nVDSYNC       = 1'b1;
    gammaparams_i = 4'd5;
    video_data_i  = '0;
    #12;
    check("reset_out", video_data_o, 25'd0);
    @(negedge VCLK);
    nRST = 1'b1;
    @(negedge VCLK);
    check("post_reset_out", video_data_o, 25'd0);

    // identity at mid-scale with hold gaps in between
    drive_px(4'd5, 4'b1010, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64);
    hold(3);
    drive_px(4'd5, 4'b0101, 7'd10, 7'd100, 7'd127, 7'd10, 7'd100, 7'd127);
    hold(2);

    // hand-computed curve points at x=64; 5->7 switch between consecutive pixels
    drive_px(4'd5, 4'b1111, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64);
    drive_px(4'd7, 4'b0000, 7'd64, 7'd64, 7'd64, 7'd72, 7'd72, 7'd72);
    drive_px(4'd2, 4'b1001, 7'd64, 7'd0, 7'd127, 7'd54, 7'd0, 7'd127);
    drive_px(4'd0, 4'b0110, 7'd64, 7'd64, 7'd0, 7'd48, 7'd48, 7'd0);
    drive_px(4'd8, 4'b0011, 7'd127, 7'd64, 7'd64, 7'd127, 7'd75, 7'd75);

    // endpoints hold for every code
    for (int c = 0; c < 16; c++) begin
      drive_px(4'(c), 4'(c), 7'd0, 7'd127, 7'd0, 7'd0, 7'd127, 7'd0);
      drive_px(4'(c), 4'(15-c), 7'd127, 7'd0, 7'd127, 7'd127, 7'd0, 7'd127);
    end

    // long hold with changing inputs
    hold(10);

    // code 12 falls back to identity across the full range
    for (int i = 0; i < 128; i++) begin
      x = 7'(i);
      drive_px(4'd12, 4'(i), x, ~x, x ^ 7'h55, x, ~x, x ^ 7'h55);
    end

    // asynchronous reset with non-zero data in flight
    drive_px(4'd5, 4'b1111, 7'd100, 7'd100, 7'd100, 7'd100, 7'd100, 7'd100);
    drive_px(4'd5, 4'b1111, 7'd101, 7'd101, 7'd101, 7'd101, 7'd101, 7'd101);
    drive_px(4'd5, 4'b1111, 7'd102, 7'd102, 7'd102, 7'd102, 7'd102, 7'd102);
    @(negedge VCLK);
    nVDSYNC = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check("async_reset_out", video_data_o, 25'd0);
    exp_q.delete();
    en_cnt = 0;
    @(negedge VCLK);
    @(negedge VCLK);
    nRST = 1'b1;
    hold(2);
    drive_px(4'd7, 4'b1010, 7'd64, 7'd127, 7'd0, 7'd72, 7'd127, 7'd0);
    drive_px(4'd5, 4'b0101, 7'd33, 7'd44, 7'd55, 7'd33, 7'd44, 7'd55);

    for (int i = 0; i < LAT; i++)
      drive_px(4'd5, 4'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    @(negedge VCLK);
    nVDSYNC = 1'b1;
    @(negedge VCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
